// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ        = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-nibble reverse double-dabble adjust (subtract 3 when >= 8) plus illegal-digit flag.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj_out,
    output logic       illegal
);

    always_comb begin
        adj_out = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adj_out = digit - BCD_ADJ;
        end
        illegal = (digit > BCD_MAX_DIGIT);
    end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Multi-digit BCD-to-binary converter: reverse double-dabble, one shift-and-adjust per clock.
module bcd_to_binary_converter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      binary_out
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [BIN_W-1:0]    bin_out_q, bin_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    adj_in;
    logic [BCD_W-1:0]    adj_out;
    logic [DIGITS-1:0]   illegal;
    logic                any_illegal;

    // The adjust cells check bcd_in while idle and adjust the shifted work register while running.
    always_comb begin
        shifted = work_q >> 1;
        adj_in  = (state_q == StIdle) ? bcd_in : shifted[WORK_W-1:BIN_W];
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit   (adj_in[4*g +: 4]),
            .adj_out (adj_out[4*g +: 4]),
            .illegal (illegal[g])
        );
    end

    assign any_illegal = |illegal;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        bin_out_d = bin_out_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    work_d = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (any_illegal) begin
                        err_d     = 1'b1;
                        bin_out_d = '0;
                        state_d   = StDone;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                work_d = {adj_out, shifted[BIN_W-1:0]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    bin_out_d = shifted[BIN_W-1:0];
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                // Illegal captures arrive with done low; raise it here so done is one full cycle.
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            work_q    <= '0;
            bin_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            bin_out_q <= bin_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign binary_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Self-checking bench: vector table, scoreboard queue, and hand sequences for multi-cycle corners.
module tb_bcd_to_binary_converter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] binary_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int bin;
        bit err;
    } exp_t;

    typedef struct {
        logic [7:0] bcd;
        int         bin;
        bit         err;
        int         lat;
        int         busy_cycles;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    bcd_to_binary_converter #(
        .DIGITS (2),
        .BIN_W  (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .binary_out (binary_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller is at the negedge after the accept edge (lat 0). Pops and compares on done.
    task automatic wait_done(input int chg_at, input logic [7:0] chg_val,
                             output int lat, output int busy_cycles);
        exp_t e;
        lat = -1;
        busy_cycles = 0;
        for (int n = 0; n < 30; n++) begin
            if (n == chg_at) bcd_in = chg_val;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            if (lat < 0) begin
                chk("done_timeout", 0, 1);
            end else begin
                chk("binary_out", int'(binary_out), e.bin);
                chk("err", int'(err), int'(e.err));
            end
        end
    endtask

    // Caller is at a negedge with the DUT idle.
    task automatic run_conv(input logic [7:0] bcd, input int exp_bin, input bit exp_err,
                            input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        bcd_in = bcd;
        start  = 1'b1;
        sb.push_back('{bin: exp_bin, err: exp_err});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(-1, 8'h00, lat, bc);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", bc, exp_busy);
        @(negedge clk);
        chk("done_pulse_end", int'(done), 0);
    endtask

    initial begin
        int lat;
        int bc;
        int done_seen;
        logic [3:0] tens;
        logic [3:0] ones;

        vecs[0] = '{bcd: 8'h99, bin: 99, err: 1'b0, lat: 7, busy_cycles: 7};
        vecs[1] = '{bcd: 8'h00, bin: 0,  err: 1'b0, lat: 7, busy_cycles: 7};
        vecs[2] = '{bcd: 8'h15, bin: 15, err: 1'b0, lat: 7, busy_cycles: 7};
        vecs[3] = '{bcd: 8'h50, bin: 50, err: 1'b0, lat: 7, busy_cycles: 7};
        vecs[4] = '{bcd: 8'h09, bin: 9,  err: 1'b0, lat: 7, busy_cycles: 7};
        vecs[5] = '{bcd: 8'h3A, bin: 0,  err: 1'b1, lat: 1, busy_cycles: 0};
        vecs[6] = '{bcd: 8'h42, bin: 42, err: 1'b0, lat: 7, busy_cycles: 7};
        vecs[7] = '{bcd: 8'hA0, bin: 0,  err: 1'b1, lat: 1, busy_cycles: 0};
        vecs[8] = '{bcd: 8'h88, bin: 88, err: 1'b0, lat: 7, busy_cycles: 7};

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_binary_out", int'(binary_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat, vecs[i].busy_cycles);
        end

        // start held high with bcd_in changing mid-run: one result, then a fresh conversion.
        bcd_in = 8'h27;
        start  = 1'b1;
        sb.push_back('{bin: 27, err: 1'b0});
        @(posedge clk);
        @(negedge clk);
        wait_done(3, 8'h81, lat, bc);
        chk("held_latency", lat, 7);
        @(negedge clk);
        chk("held_done_single", int'(done), 0);
        chk("held_idle_not_busy", int'(busy), 0);
        sb.push_back('{bin: 81, err: 1'b0});
        @(negedge clk);
        chk("held_restart_busy", int'(busy), 1);
        start = 1'b0;
        wait_done(-1, 8'h00, lat, bc);
        chk("held2_latency", lat, 7);
        @(negedge clk);

        // Restore a nonzero result so the reset check below is meaningful.
        run_conv(8'h42, 42, 1'b0, 7, 7);

        // Reset mid-RUN aborts the conversion without a done.
        bcd_in = 8'h64;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_binary_out", int'(binary_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_conv(8'h64, 64, 1'b0, 7, 7);

        // Loopback against a bench-side binary-to-BCD split.
        for (int i = 0; i < 16; i++) begin
            tens = 4'(i / 10);
            ones = 4'(i % 10);
            run_conv({tens, ones}, i, 1'b0, 7, 7);
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
